fir_filter_tdm: RTL and testbench

Parametrised, time-multiplexed FIR filter for the adaptive-filter chain. It stores TAPS samples in a circular delay line and computes each output with a single pipelined multiplier over TAPS cycles. Coefficients are loaded at run time through a write port, so an adaptation engine can update them between samples. Samples enter and results leave through valid/ready handshakes.

---
 rtl/fir_pkg.sv | 19 +
 rtl/fir_mac.sv | 56 +++++
 rtl/fir_filter_tdm.sv | 181 ++++++++++++++++++
 tb/tb_fir_filter_tdm.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the time-multiplexed FIR filter and the adaptive
// update blocks: FSM state encoding and accumulator width helper.
package fir_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MAC   = 2'd1,
      DRAIN = 2'd2,
      OUT   = 2'd3
   } fir_state_e;

   // Accumulator width that can hold the sum of taps full-precision products.
   function automatic int unsigned fir_acc_w(input int unsigned data_w,
                                             input int unsigned coef_w,
                                             input int unsigned taps);
      return data_w + coef_w + $clog2(taps);
   endfunction

endpackage

// File: rtl/fir_mac.sv
// Registered signed multiplier feeding an accumulator.
// clear zeroes product and accumulator, en multiplies and accumulates the
// previous product, flush accumulates the last product without a new multiply.
// acc_next exposes the value the accumulator is about to take.
module fir_mac #(
   parameter int DATA_W = 16,
   parameter int COEF_W = 16,
   parameter int ACC_W  = 39
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              en,
   input  logic              flush,
   input  logic [DATA_W-1:0] sample,
   input  logic [COEF_W-1:0] coef,
   output logic [ACC_W-1:0]  acc_next
);

   localparam int PROD_W = DATA_W + COEF_W;

   logic signed [PROD_W-1:0] prod_q, prod_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic signed [ACC_W-1:0]  prod_ext;

   // Next product / accumulator selection from the control strobes.
   always_comb begin
      prod_ext = {{(ACC_W - PROD_W){prod_q[PROD_W-1]}}, prod_q};
      prod_d   = prod_q;
      acc_d    = acc_q;
      if (clear) begin
         prod_d = '0;
         acc_d  = '0;
      end else if (en) begin
         prod_d = PROD_W'($signed(sample)) * PROD_W'($signed(coef));
         acc_d  = acc_q + prod_ext;
      end else if (flush) begin
         prod_d = '0;
         acc_d  = acc_q + prod_ext;
      end
   end

   assign acc_next = acc_d;

   // Product and accumulator registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prod_q <= '0;
         acc_q  <= '0;
      end else begin
         prod_q <= prod_d;
         acc_q  <= acc_d;
      end
   end

endmodule

// File: rtl/fir_filter_tdm.sv
// Time-multiplexed FIR filter: circular delay line, run-time coefficient bank,
// one pipelined MAC walked over all taps per sample, valid/ready at both ends.
// Optional macro FIR_SAT_EN: saturate the shifted result to OUT_W instead of
// wrapping to its low OUT_W bits.
module fir_filter_tdm
   import fir_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int COEF_W    = 16,
   parameter int TAPS      = 101,
   parameter int OUT_W     = 32,
   parameter int OUT_SHIFT = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        in_sample,
   input  logic                     coef_we,
   input  logic [$clog2(TAPS)-1:0]  coef_addr,
   input  logic [COEF_W-1:0]        coef_data,
   output logic                     coef_drop,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [OUT_W-1:0]         out_sample,
   output logic                     busy
);

   localparam int          AW     = $clog2(TAPS);
   localparam int          ACC_W  = fir_acc_w(DATA_W, COEF_W, TAPS);
   localparam logic [AW-1:0] K_LAST = AW'(TAPS - 1);
   localparam logic [AW:0]   TAPS_W = (AW + 1)'(TAPS);

   fir_state_e state_q, state_d;

   logic [DATA_W-1:0] line_q [TAPS];
   logic [DATA_W-1:0] line_d [TAPS];
   logic [COEF_W-1:0] coef_q [TAPS];
   logic [COEF_W-1:0] coef_d [TAPS];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     k_q, k_d;
   logic [AW-1:0]     rd_idx;
   logic [OUT_W-1:0]  out_sample_q, out_sample_d;
   logic              coef_drop_q, coef_drop_d;

   logic              accept;
   logic              mac_clear, mac_en, mac_flush;
   logic signed [ACC_W-1:0] acc_next;
   logic signed [ACC_W-1:0] shifted;
   logic [OUT_W-1:0]  result;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (accept) state_d = MAC;
         MAC:   if (k_q == K_LAST) state_d = DRAIN;
         DRAIN: state_d = OUT;
         OUT:   if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs and MAC controls; in_ready is masked while reset is held.
   always_comb begin
      in_ready  = (state_q == IDLE) && !rst;
      out_valid = (state_q == OUT);
      busy      = (state_q != IDLE);
      accept    = in_valid && in_ready;
      mac_clear = accept;
      mac_en    = (state_q == MAC);
      mac_flush = (state_q == DRAIN);
   end

   // Read address x[n-k] = line[(wr_ptr - k) mod TAPS]; the AW-bit wrap keeps
   // the modular result correct because the true index is always below TAPS.
   always_comb begin
      if (wr_ptr_q >= k_q) rd_idx = wr_ptr_q - k_q;
      else                 rd_idx = wr_ptr_q - k_q + AW'(TAPS);
   end

   fir_mac #(
      .DATA_W (DATA_W),
      .COEF_W (COEF_W),
      .ACC_W  (ACC_W)
   ) u_mac (
      .clk      (clk),
      .rst      (rst),
      .clear    (mac_clear),
      .en       (mac_en),
      .flush    (mac_flush),
      .sample   (line_q[rd_idx]),
      .coef     (coef_q[k_q]),
      .acc_next (acc_next)
   );

   // Output scaling: arithmetic shift, then saturate or wrap to OUT_W.
   always_comb begin
      shifted = acc_next >>> OUT_SHIFT;
`ifdef FIR_SAT_EN
      result = sat_out(shifted);
`else
      result = OUT_W'(shifted);
`endif
   end

`ifdef FIR_SAT_EN
   localparam int WIDE_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;
   localparam logic signed [WIDE_W-1:0] SAT_MAX =
      {{(WIDE_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
   localparam logic signed [WIDE_W-1:0] SAT_MIN = ~SAT_MAX;

   function automatic logic [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] v);
      logic signed [WIDE_W-1:0] wide;
      wide = WIDE_W'(v);
      if (wide > SAT_MAX)      return SAT_MAX[OUT_W-1:0];
      else if (wide < SAT_MIN) return SAT_MIN[OUT_W-1:0];
      else                     return wide[OUT_W-1:0];
   endfunction
`endif

   // Datapath next-state: delay line, coefficient bank, pointers, output.
   always_comb begin
      line_d       = line_q;
      coef_d       = coef_q;
      wr_ptr_d     = wr_ptr_q;
      k_d          = k_q;
      out_sample_d = out_sample_q;
      coef_drop_d  = coef_we && (state_q != IDLE);

      if (accept) begin
         line_d[wr_ptr_q] = in_sample;
         k_d              = '0;
      end

      if (coef_we && (state_q == IDLE) && ({1'b0, coef_addr} < TAPS_W))
         coef_d[coef_addr] = coef_data;

      if (state_q == MAC) begin
         if (k_q == K_LAST) k_d = '0;
         else               k_d = k_q + 1'b1;
      end

      if (state_q == DRAIN)
         out_sample_d = result;

      if ((state_q == OUT) && out_ready) begin
         if (wr_ptr_q == K_LAST) wr_ptr_d = '0;
         else                    wr_ptr_d = wr_ptr_q + 1'b1;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         line_q       <= '{default: '0};
         coef_q       <= '{default: '0};
         wr_ptr_q     <= '0;
         k_q          <= '0;
         out_sample_q <= '0;
         coef_drop_q  <= 1'b0;
      end else begin
         line_q       <= line_d;
         coef_q       <= coef_d;
         wr_ptr_q     <= wr_ptr_d;
         k_q          <= k_d;
         out_sample_q <= out_sample_d;
         coef_drop_q  <= coef_drop_d;
      end
   end

   assign out_sample = out_sample_q;
   assign coef_drop  = coef_drop_q;

endmodule

// File: tb/tb_fir_filter_tdm.sv
// Self-checking bench: a 4-tap instance for impulse, wrap-around, backpressure,
// coefficient-drop and random tests, and a 101-tap default instance for the
// saturation and mid-MAC reset cases. Expected outputs come from a direct
// convolution over the sample history.
module tb_fir_filter_tdm;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // 4-tap instance
   logic        a_rst, a_in_valid, a_in_ready, a_coef_we, a_coef_drop;
   logic        a_out_valid, a_out_ready, a_busy;
   logic [15:0] a_in_sample, a_coef_data;
   logic [1:0]  a_coef_addr;
   logic [31:0] a_out_sample;

   // 101-tap instance
   logic        b_rst, b_in_valid, b_in_ready, b_coef_we, b_coef_drop;
   logic        b_out_valid, b_out_ready, b_busy;
   logic [15:0] b_in_sample, b_coef_data;
   logic [6:0]  b_coef_addr;
   logic [31:0] b_out_sample;

   fir_filter_tdm #(.DATA_W(16), .COEF_W(16), .TAPS(4), .OUT_W(32), .OUT_SHIFT(0)) dut4 (
      .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_sample(a_in_sample), .coef_we(a_coef_we), .coef_addr(a_coef_addr),
      .coef_data(a_coef_data), .coef_drop(a_coef_drop), .out_valid(a_out_valid),
      .out_ready(a_out_ready), .out_sample(a_out_sample), .busy(a_busy));

   fir_filter_tdm #(.TAPS(101)) dut101 (
      .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_sample(b_in_sample), .coef_we(b_coef_we), .coef_addr(b_coef_addr),
      .coef_data(b_coef_data), .coef_drop(b_coef_drop), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .out_sample(b_out_sample), .busy(b_busy));

   longint a_h[$], a_x[$], b_h[$], b_x[$];

   typedef struct {
      int          x;
      logic [31:0] y;
   } vec_t;

   vec_t imp_tab[5];
   vec_t wrap_tab[9];

   function automatic logic [31:0] reduce(input longint v);
`ifdef FIR_SAT_EN
      if (v > 64'sd2147483647)  return 32'h7fff_ffff;
      if (v < -64'sd2147483648) return 32'h8000_0000;
`endif
      return v[31:0];
   endfunction

   // y[n] = sum_k h[k] * x[n-k], samples before the first one are zero.
   function automatic logic [31:0] fir_ref(input longint xs[$], input longint hs[$]);
      longint acc = 0;
      int n = xs.size() - 1;
      for (int k = 0; k < hs.size(); k++)
         if (n - k >= 0) acc += hs[k] * xs[n - k];
      return reduce(acc);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic int rnd16;
      logic signed [15:0] r;
      r = 16'($urandom);
      return int'(r);
   endfunction

   // ---------------- 4-tap helpers ----------------
   task automatic a_wcoef(input int addr, input int val);
      a_coef_we   = 1'b1;
      a_coef_addr = 2'(addr);
      a_coef_data = 16'(val);
      tick;
      a_coef_we   = 1'b0;
      a_h[addr]   = val;
   endtask

   task automatic a_start(input int x);
      int n = 0;
      a_in_valid  = 1'b1;
      a_in_sample = 16'(x);
      while (!a_in_ready && n < 300) begin tick; n++; end
      check("a_in_ready_wait", 32'(a_in_ready), 32'd1);
      tick;
      a_in_valid = 1'b0;
      a_x.push_back(x);
   endtask

   task automatic a_finish(output logic [31:0] y, output int lat);
      lat = 1;
      while (!a_out_valid && lat < 300) begin tick; lat++; end
      check("a_out_valid_wait", 32'(a_out_valid), 32'd1);
      y = a_out_sample;
      a_out_ready = 1'b1;
      tick;
      a_out_ready = 1'b0;
   endtask

   // ---------------- 101-tap helpers ----------------
   task automatic b_wcoef(input int addr, input int val);
      b_coef_we   = 1'b1;
      b_coef_addr = 7'(addr);
      b_coef_data = 16'(val);
      tick;
      b_coef_we   = 1'b0;
      b_h[addr]   = val;
   endtask

   task automatic b_start(input int x);
      int n = 0;
      b_in_valid  = 1'b1;
      b_in_sample = 16'(x);
      while (!b_in_ready && n < 300) begin tick; n++; end
      check("b_in_ready_wait", 32'(b_in_ready), 32'd1);
      tick;
      b_in_valid = 1'b0;
      b_x.push_back(x);
   endtask

   task automatic b_finish(output logic [31:0] y, output int lat);
      lat = 1;
      while (!b_out_valid && lat < 300) begin tick; lat++; end
      check("b_out_valid_wait", 32'(b_out_valid), 32'd1);
      y = b_out_sample;
      b_out_ready = 1'b1;
      tick;
      b_out_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] y, y0, exp_sat;
      int lat;

      imp_tab[0] = '{1, 32'd1}; imp_tab[1] = '{0, 32'd2}; imp_tab[2] = '{0, 32'd3};
      imp_tab[3] = '{0, 32'd4}; imp_tab[4] = '{0, 32'd0};
      wrap_tab[0] = '{1, 32'd1};  wrap_tab[1] = '{2, 32'd3};  wrap_tab[2] = '{3, 32'd6};
      wrap_tab[3] = '{4, 32'd10}; wrap_tab[4] = '{5, 32'd14}; wrap_tab[5] = '{6, 32'd18};
      wrap_tab[6] = '{7, 32'd22}; wrap_tab[7] = '{8, 32'd26}; wrap_tab[8] = '{9, 32'd30};

      a_rst = 1'b1; a_in_valid = 1'b0; a_in_sample = '0; a_coef_we = 1'b0;
      a_coef_addr = '0; a_coef_data = '0; a_out_ready = 1'b0;
      b_rst = 1'b1; b_in_valid = 1'b0; b_in_sample = '0; b_coef_we = 1'b0;
      b_coef_addr = '0; b_coef_data = '0; b_out_ready = 1'b0;
      for (int i = 0; i < 4; i++)   a_h.push_back(0);
      for (int i = 0; i < 101; i++) b_h.push_back(0);

      // Reset state
      tick;
      check("rst_a_in_ready", 32'(a_in_ready), 32'd0);
      check("rst_b_in_ready", 32'(b_in_ready), 32'd0);
      check("rst_a_out_valid", 32'(a_out_valid), 32'd0);
      check("rst_a_busy", 32'(a_busy), 32'd0);
      check("rst_a_out_sample", a_out_sample, 32'd0);
      check("rst_a_coef_drop", 32'(a_coef_drop), 32'd0);
      a_rst = 1'b0;
      b_rst = 1'b0;
      tick;
      check("rel_a_in_ready", 32'(a_in_ready), 32'd1);
      check("rel_b_in_ready", 32'(b_in_ready), 32'd1);

      // Impulse response, h = {1,2,3,4}
      for (int k = 0; k < 4; k++) a_wcoef(k, k + 1);
      for (int i = 0; i < 5; i++) begin
         a_start(imp_tab[i].x);
         a_finish(y, lat);
         check("imp_y", y, imp_tab[i].y);
         check("imp_lat", 32'(lat), 32'd6);
      end

      // Wrap-around of the delay line, h = {1,1,1,1}
      for (int k = 0; k < 4; k++) a_wcoef(k, 1);
      for (int i = 0; i < 9; i++) begin
         a_start(wrap_tab[i].x);
         a_finish(y, lat);
         check("wrap_y", y, wrap_tab[i].y);
         check("wrap_model", y, fir_ref(a_x, a_h));
      end

      // Backpressure: a second sample is offered while the result is held
      a_start(7);
      a_in_valid  = 1'b1;
      a_in_sample = 16'hfffb;
      lat = 1;
      while (!a_out_valid && lat < 300) begin tick; lat++; end
      check("bp_valid_rise", 32'(a_out_valid), 32'd1);
      check("bp_ready_mac", 32'(a_in_ready), 32'd0);
      y0 = a_out_sample;
      check("bp_value", y0, fir_ref(a_x, a_h));
      for (int i = 0; i < 10; i++) begin
         tick;
         check("bp_hold_valid", 32'(a_out_valid), 32'd1);
         check("bp_hold_sample", a_out_sample, y0);
         check("bp_hold_ready", 32'(a_in_ready), 32'd0);
      end
      a_out_ready = 1'b1;
      tick;
      a_out_ready = 1'b0;
      check("bp_after_valid", 32'(a_out_valid), 32'd0);
      check("bp_after_ready", 32'(a_in_ready), 32'd1);
      a_start(-5);
      a_finish(y, lat);
      check("bp_pending_y", y, fir_ref(a_x, a_h));

      // Coefficient write during MAC is dropped; a write in IDLE applies next
      a_start(3);
      tick;
      a_coef_we = 1'b1; a_coef_addr = 2'd0; a_coef_data = 16'd100;
      tick;
      a_coef_we = 1'b0;
      check("drop_pulse", 32'(a_coef_drop), 32'd1);
      tick;
      check("drop_single", 32'(a_coef_drop), 32'd0);
      a_finish(y, lat);
      check("drop_old_coef", y, fir_ref(a_x, a_h));
      a_wcoef(0, 100);
      check("idle_no_drop", 32'(a_coef_drop), 32'd0);
      a_start(2);
      a_finish(y, lat);
      check("idle_new_coef", y, fir_ref(a_x, a_h));

      // Random samples, with coefficient writes coinciding with the accept
      for (int i = 0; i < 24; i++) begin
         int x, addr, val;
         x = rnd16();
         if ($urandom_range(0, 1) == 1) begin
            addr = int'($urandom_range(0, 3));
            val  = rnd16();
            a_coef_we   = 1'b1;
            a_coef_addr = 2'(addr);
            a_coef_data = 16'(val);
            a_h[addr]   = val;
         end
         a_start(x);
         a_coef_we = 1'b0;
         a_finish(y, lat);
         check("rand_y", y, fir_ref(a_x, a_h));
         check("rand_lat", 32'(lat), 32'd6);
      end

      // Saturation / wrap, 101 taps of -32768 times 101 samples of -32768
      for (int k = 0; k < 101; k++) b_wcoef(k, -32768);
      for (int i = 0; i < 101; i++) begin
         b_start(-32768);
         b_finish(y, lat);
         if (i == 0) check("b_lat", 32'(lat), 32'd103);
      end
`ifdef FIR_SAT_EN
      exp_sat = 32'h7fff_ffff;
`else
      exp_sat = 32'h4000_0000;
`endif
      check("sat_y", y, exp_sat);
      check("sat_model", y, fir_ref(b_x, b_h));

      // Reset at MAC cycle 50 abandons the computation
      b_start(5);
      for (int i = 0; i < 50; i++) tick;
      check("midmac_busy", 32'(b_busy), 32'd1);
      b_rst = 1'b1;
      #1;
      check("mrst_in_ready", 32'(b_in_ready), 32'd0);
      check("mrst_out_valid", 32'(b_out_valid), 32'd0);
      check("mrst_out_sample", b_out_sample, 32'd0);
      check("mrst_coef_drop", 32'(b_coef_drop), 32'd0);
      check("mrst_busy", 32'(b_busy), 32'd0);
      tick;
      b_rst = 1'b0;
      for (int k = 0; k < 101; k++) b_h[k] = 0;
      b_x.delete();
      tick;
      check("mrst_rel_ready", 32'(b_in_ready), 32'd1);
      check("mrst_rel_valid", 32'(b_out_valid), 32'd0);
      b_start(1);
      b_finish(y, lat);
      check("mrst_impulse0", y, 32'd0);
      b_start(1000);
      b_finish(y, lat);
      check("mrst_impulse1", y, fir_ref(b_x, b_h));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
